// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes and multiplier sequencer state type
package alu_pkg;

  localparam logic [2:0] ALU_PASS_B   = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b010;
  localparam logic [2:0] ALU_SUBTRACT = 3'b011;
  localparam logic [2:0] ALU_AND      = 3'b100;
  localparam logic [2:0] ALU_OR       = 3'b101;
  localparam logic [2:0] ALU_XOR      = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared combinational execute-stage ALU
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    case (cntrl)
      ALU_PASS_B:   result = b;
      ALU_ADD:      {carry_out, result} = sum;
      ALU_SUBTRACT: {carry_out, result} = diff;
      ALU_AND:      result = a & b;
      ALU_OR:       result = a | b;
      ALU_XOR:      result = a ^ b;
      default:      result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-add multiplier that borrows the shared ALU adder
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out
);

  mul_state_t       state, state_nxt;
  logic [WIDTH-1:0] acc, mc, mp;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lost, sticky, sticky_nxt;
  logic             accept, last_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    alu_a      = '0;
    alu_b      = '0;
    alu_cntrl  = ALU_PASS_B;
    accept     = 1'b0;
    last_run   = 1'b0;
    acc_nxt    = acc;
    sticky_nxt = sticky;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (mplr == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        alu_a     = acc;
        alu_b     = mc;
        alu_cntrl = ALU_ADD;
        // A set bit lost off mc's top means this partial product already exceeds WIDTH bits.
        if (mp[0]) begin
          acc_nxt    = alu_result;
          sticky_nxt = sticky | alu_carry_out | lost;
        end
        if (mp[WIDTH-1:1] == '0 || cnt == CNT_W'(WIDTH - 1)) begin
          last_run  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
      cnt     <= '0;
      lost    <= 1'b0;
      sticky  <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      mc     <= mcand;
      mp     <= mplr;
      cnt    <= '0;
      lost   <= 1'b0;
      sticky <= 1'b0;
      if (mplr == '0) begin
        product <= '0;
        ovf     <= 1'b0;
      end
    end else if (state == RUN) begin
      acc    <= acc_nxt;
      sticky <= sticky_nxt;
      mc     <= mc << 1;
      lost   <= lost | mc[WIDTH-1];
      mp     <= mp >> 1;
      cnt    <= cnt + CNT_W'(1);
      // Result is published as DONE is entered so it is valid alongside the done pulse.
      if (last_run) begin
        product <= acc_nxt;
        ovf     <= sticky_nxt;
      end
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - randomized self-checking bench for alu_mul_sequencer with the shared ALU
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] mcand = '0;
  logic [63:0] mplr = '0;
  logic        busy, done, ovf, alu_carry_out;
  logic [63:0] product, alu_a, alu_b, alu_result;
  logic [2:0]  alu_cntrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mcand(mcand), .mplr(mplr),
    .busy(busy), .done(done), .product(product), .ovf(ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  alu #(.WIDTH(64)) u_alu (
    .a(alu_a), .b(alu_b), .cntrl(alu_cntrl),
    .result(alu_result), .carry_out(alu_carry_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int msb_idx(input logic [63:0] v);
    for (int i = 63; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  // Issues one multiply, scrambles the operand inputs during RUN, and checks against plain arithmetic.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input string tag);
    logic [127:0] full;
    int           exp_lat, lat, runs;
    logic [63:0]  got_p;
    logic         got_o;
    full    = {64'd0, a} * {64'd0, b};
    exp_lat = (b == 0) ? 1 : msb_idx(b) + 2;
    @(negedge clk);
    mcand = a;
    mplr  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mcand = {$urandom, $urandom};
    mplr  = {$urandom, $urandom};
    lat = 0;
    runs = 0;
    got_p = '0;
    got_o = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (alu_cntrl == 3'b010) runs++;
      if (done) begin
        lat   = c;
        got_p = product;
        got_o = ovf;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) check({tag, " timeout"}, 128'(0), 128'(1));
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " add_cycles"}, 128'(runs), 128'(exp_lat - 1));
    check({tag, " product"}, 128'(got_p), full & {64'd0, {64{1'b1}}});
    check({tag, " ovf"}, 128'(got_o), 128'(full[127:64] != 0));
    @(negedge clk);
    check({tag, " done_one_cycle"}, 128'({done, busy}), 128'(0));
  endtask

  initial begin
    int n_done;
    logic [63:0] ra, rb;

    #1;
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset product", 128'(product), 128'(0));
    check("reset ovf", 128'(ovf), 128'(0));
    check("reset alu_cntrl", 128'(alu_cntrl), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    run_op(64'd3, 64'd5, "small");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "mplr_zero");
    run_op(64'd0, 64'h8000_0000_0000_0000, "mcand_zero");
    run_op(64'h8000_0000_0000_0000, 64'd2, "lost_bit");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "all_ones");

    // Reset in the middle of a RUN: outputs clear asynchronously and no done ever follows.
    @(negedge clk);
    mcand = 64'd7;
    mplr  = 64'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrun busy_before", 128'(busy), 128'(1));
    reset_n = 1'b0;
    #1;
    check("midrun busy", 128'(busy), 128'(0));
    check("midrun done", 128'(done), 128'(0));
    check("midrun product", 128'(product), 128'(0));
    check("midrun ovf", 128'(ovf), 128'(0));
    check("midrun alu_cntrl", 128'(alu_cntrl), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrun no_done", 128'(n_done), 128'(0));

    // start held high: 3*5 completes once, then 2*2 is accepted in the IDLE cycle after done.
    @(negedge clk);
    mcand = 64'd3;
    mplr  = 64'd5;
    start = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (c == 4) begin
        check("hold done_at_4", 128'(done), 128'(1));
        check("hold product_15", 128'(product), 128'(15));
        mcand = 64'd2;
        mplr  = 64'd2;
      end
      if (c == 5) check("hold idle_after_done", 128'({busy, done}), 128'(0));
      if (c == 6) start = 1'b0;
      if (c == 6 || c == 7) check("hold product_kept", 128'({busy, product}), {63'd0, 1'b1, 64'd15});
      if (c == 8) begin
        check("hold second_done", 128'(done), 128'(1));
        check("hold product_4", 128'(product), 128'(4));
      end
    end
    check("hold done_count", 128'(n_done), 128'(2));

    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 3 == 1) rb = rb >> $urandom_range(0, 63);
      if (i % 7 == 3) ra = ra >> $urandom_range(0, 63);
      if (i % 50 == 10) rb = '0;
      run_op(ra, rb, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
